// File: rtl/pc_sequencer.sv
// Program-counter sequencer: turns one-cycle next/jump/call/restart requests
// into ordered PC mode codes, drives the shared bus on loads, captures call returns.
module pc_sequencer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RET_OFFSET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] target,
  output logic [2:0]        pc_mode,
  inout  wire  [ADDR_W-1:0] data_bus,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_valid,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // BOOT  | in/just out of reset, PC held clear
  // IDLE  | waiting for start
  // INC   | PC increments on exit edge
  // LOAD  | target_q on bus, PC loads on exit edge
  // READ  | PC drives bus, return address captured on exit edge
  // CLR   | PC zeroes on exit edge
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {BOOT, IDLE, INC, LOAD, READ, CLR, DONE} state_t;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;

  state_t            state;
  state_t            next_state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] target_q;
  logic              drive;

  function automatic logic [2:0] mode_of(input state_t s);
    case (s)
      INC:        mode_of = 3'b100;
      LOAD:       mode_of = 3'b001;
      READ:       mode_of = 3'b010;
      IDLE, DONE: mode_of = 3'b011;
      default:    mode_of = 3'b000;
    endcase
  endfunction

  always_comb begin
    next_state = state;
    case (state)
      BOOT: next_state = IDLE;
      IDLE: begin
        if (start) begin
          case (op)
            OP_NEXT: next_state = INC;
            OP_JUMP: next_state = LOAD;
            OP_CALL: next_state = READ;
            default: next_state = CLR;
          endcase
        end
      end
      INC, LOAD, CLR: next_state = DONE;
      // READ is only reachable from a call; the check keeps a corrupted op_q from loading
      READ:    next_state = (op_q == OP_CALL) ? LOAD : DONE;
      DONE:    next_state = IDLE;
      default: next_state = BOOT;
    endcase
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      pc_mode   <= 3'b000;
      busy      <= 1'b1;
      done      <= 1'b0;
      drive     <= 1'b0;
      op_q      <= 2'b00;
      target_q  <= '0;
      ret_addr  <= '0;
      ret_valid <= 1'b0;
    end else begin
      state   <= next_state;
      pc_mode <= mode_of(next_state);
      busy    <= (next_state != IDLE);
      done    <= (next_state == DONE);
      drive   <= (next_state == LOAD);
      if (state == IDLE && start) begin
        op_q      <= op;
        target_q  <= target;
        ret_valid <= 1'b0;
      end
      if (state == READ) begin
        ret_addr  <= data_bus + ADDR_W'(RET_OFFSET);
        ret_valid <= 1'b1;
      end
    end
  end

  assign data_bus = drive ? target_q : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a behavioural PC on the shared bus.
module tb_pc_sequencer;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] target = '0;
  logic [2:0]  pc_mode;
  wire  [31:0] data_bus;
  logic [31:0] ret_addr;
  logic        ret_valid, busy, done;

  pc_sequencer #(.ADDR_W(32), .RET_OFFSET(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .target(target),
    .pc_mode(pc_mode), .data_bus(data_bus), .ret_addr(ret_addr),
    .ret_valid(ret_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Behavioural program counter obeying the mode code
  logic [31:0] pc_q = '0;
  always @(posedge clock) begin
    case (pc_mode)
      3'b000:  pc_q <= '0;
      3'b001:  pc_q <= data_bus;
      3'b100:  pc_q <= pc_q + 32'd1;
      default: pc_q <= pc_q;
    endcase
  end
  assign data_bus = (pc_mode == 3'b010) ? pc_q : 32'bz;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt = edge_cnt + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    logic        rv;
    int          lat;
    logic [8:0]  modes;
    int          n_modes;
    int          accept_edge;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ref_pc = '0;
  logic [31:0] ref_ret = '0;
  logic [31:0] cur_tgt = '0;
  logic        active = 1'b0;
  logic [2:0]  seen_modes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT reports completion
  always @(negedge clock) begin
    if (reset_n) begin
      if (active) seen_modes.push_back(pc_mode);
      if (pc_mode == 3'b001) check("load_bus", data_bus, cur_tgt);
      else if (pc_mode != 3'b010 && cur_tgt != 0) begin
        tests++;
        if (data_bus === cur_tgt) begin
          fails++;
          $display("FAIL bus_idle: got %h while not loading", data_bus);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          exp_t e;
          logic [8:0] got_modes;
          e = sb.pop_front();
          got_modes = '0;
          foreach (seen_modes[i]) if (i < 3) got_modes[3*i +: 3] = seen_modes[i];
          check("pc_value", pc_q, e.pc);
          check("latency", 32'(edge_cnt - e.accept_edge + 1), 32'(e.lat));
          check("ret_valid", {31'd0, ret_valid}, {31'd0, e.rv});
          check("ret_addr", ret_addr, e.ret);
          check("mode_seq", {23'd0, got_modes}, {23'd0, e.modes});
          check("mode_cnt", 32'(seen_modes.size()), 32'(e.n_modes));
          seen_modes.delete();
          active = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] o, input logic [31:0] t);
    exp_t e;
    int guard = 0;
    while (busy && guard < 50) begin @(negedge clock); guard++; end
    if (guard >= 50) begin tests++; fails++; $display("FAIL idle_timeout: busy stuck high"); end
    start = 1'b1; op = o; target = t;
    @(posedge clock); #1;
    e.accept_edge = edge_cnt;
    cur_tgt = t;
    case (o)
      2'b00: begin ref_pc = ref_pc + 1; e.lat = 2; e.modes = {3'b000, 3'b011, 3'b100}; e.n_modes = 2; end
      2'b01: begin ref_pc = t;          e.lat = 2; e.modes = {3'b000, 3'b011, 3'b001}; e.n_modes = 2; end
      2'b10: begin ref_ret = ref_pc + 1; ref_pc = t; e.lat = 3;
                   e.modes = {3'b011, 3'b001, 3'b010}; e.n_modes = 3; end
      default: begin ref_pc = '0;       e.lat = 2; e.modes = {3'b000, 3'b011, 3'b000}; e.n_modes = 2; end
    endcase
    e.pc = ref_pc; e.rv = (o == 2'b10); e.ret = ref_ret;
    sb.push_back(e);
    active = 1'b1;
    check("rv_cleared_at_accept", {31'd0, ret_valid && o != 2'b10 ? 1'b1 : 1'b0}, 32'd0);
    guard = 0;
    // Noise while busy: restart requests that must be ignored
    @(negedge clock);
    while (busy && guard < 50) begin
      start = 1'($urandom_range(0, 1)); op = 2'b11; target = $urandom;
      @(negedge clock); guard++;
    end
    if (guard >= 50) begin tests++; fails++; $display("FAIL done_timeout: request never finished"); end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (3) begin
      @(negedge clock);
      check("rst_mode", {29'd0, pc_mode}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ret", ret_addr, 32'd0);
      check("rst_rv", {31'd0, ret_valid}, 32'd0);
    end
    reset_n = 1'b1;
    #1 check("boot_mode", {29'd0, pc_mode}, 32'd0);
    check("boot_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    check("idle_mode", {29'd0, pc_mode}, 32'd3);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("pc_after_reset", pc_q, 32'd0);

    do_req(2'b00, 32'h0);
    do_req(2'b00, 32'h0);
    do_req(2'b01, 32'h0000_1234);
    do_req(2'b01, 32'h0000_0055);
    do_req(2'b10, 32'h0000_0800);
    do_req(2'b11, 32'h0000_0007);
    do_req(2'b01, 32'hFFFF_FFFF);
    do_req(2'b10, 32'h0000_0321);
    check("wrap_ret", ret_addr, 32'h0000_0000);

    for (int i = 0; i < 40; i++) do_req(2'($urandom_range(0, 3)), $urandom | 32'd1);

    // Reset asserted during READ of a call
    guard = 0;
    while (busy && guard < 50) begin @(negedge clock); guard++; end
    start = 1'b1; op = 2'b10; target = 32'h0000_0A0A;
    cur_tgt = 32'h0000_0A0A;
    @(negedge clock);
    start = 1'b0;
    check("pre_rst_mode_read", {29'd0, pc_mode}, 32'd2);
    #2 reset_n = 1'b0;
    #1 check("midrst_mode", {29'd0, pc_mode}, 32'd0);
    check("midrst_rv", {31'd0, ret_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd1);
    tests++;
    if (data_bus === cur_tgt) begin fails++; $display("FAIL midrst_bus: got %h driven", data_bus); end
    repeat (2) @(negedge clock);
    check("midrst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    ref_pc = '0; ref_ret = '0;
    check("post_rst_pc", pc_q, 32'd0);
    do_req(2'b00, 32'h0);

    repeat (4) @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
